// File: rtl/match_count_pkg.sv
// Shared types and constants for the match_count_ctrl sequencing counter.
package match_count_pkg;

  localparam int DEFAULT_DATA_WIDTH = 13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/comparatorEqual.sv
// Equality comparator used for terminal-count detection.
module comparatorEqual #(
  parameter int DATA_WIDTH = 13
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/match_count_ctrl.sv
// Programmable up-counter with start/done handshake and terminal-match pulse.
// Optional MATCH_COUNT_AUTO_RELOAD_EN: stay in RUN and restart from 0 on every terminal.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start_i; count_o holds the last terminal value
//   ST_RUN  | counting enabled cycles toward the latched limit
module match_count_ctrl
  import match_count_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] limit_i,
  output logic [DATA_WIDTH-1:0] count_o,
  output logic                  busy_o,
  output logic                  match_o,
  output logic                  done_o
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] limit_q;
  logic                  term_hit;

  comparatorEqual #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_term_cmp (
    .a_i  (count_o),
    .b_i  (limit_q),
    .eq_o (term_hit)
  );

  // The terminal compare is checked before the increment, so an all-ones
  // limit stops at the top value and the adder never wraps.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      count_o <= '0;
      busy_o  <= 1'b0;
      match_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      match_o <= 1'b0;
      done_o  <= 1'b0;
      if (clear_i) begin
        state_q <= ST_IDLE;
        count_o <= '0;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              limit_q <= limit_i;
              count_o <= '0;
              busy_o  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (enable_i) begin
              if (term_hit) begin
                match_o <= 1'b1;
`ifdef MATCH_COUNT_AUTO_RELOAD_EN
                count_o <= '0;
`else
                done_o  <= 1'b1;
                busy_o  <= 1'b0;
                state_q <= ST_IDLE;
`endif
              end else begin
                count_o <= count_o + DATA_WIDTH'(1);
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_match_count_ctrl.sv
// Scoreboard bench for match_count_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_match_count_ctrl;

  localparam int W = 13;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         start_i = 1'b0;
  logic         clear_i = 1'b0;
  logic         enable_i = 1'b0;
  logic [W-1:0] limit_i = '0;
  logic [W-1:0] count_o;
  logic         busy_o;
  logic         match_o;
  logic         done_o;

  match_count_ctrl #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .start_i  (start_i),
    .clear_i  (clear_i),
    .enable_i (enable_i),
    .limit_i  (limit_i),
    .count_o  (count_o),
    .busy_o   (busy_o),
    .match_o  (match_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int           cyc;
    logic [W-1:0] count;
    logic         busy;
  } snap_t;

  typedef struct {
    int           cyc;
    logic [W-1:0] count;
    logic         done;
  } pulse_t;

  snap_t  snapq[$];
  pulse_t evq[$];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  logic   finish_req = 1'b0;
  logic   finished = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: snapshot checks at their cycle, pulse checks whenever match/done shows up.
  always @(negedge clk_i) begin
    snap_t  s;
    pulse_t e;
    while (snapq.size() > 0 && snapq[0].cyc <= cyc) begin
      s = snapq.pop_front();
      n_tests++;
      if (s.cyc != cyc) begin
        n_fail++;
        $display("FAIL snap_missed cyc=%0d want_cyc=%0d", cyc, s.cyc);
      end else if (count_o !== s.count || busy_o !== s.busy) begin
        n_fail++;
        $display("FAIL snap cyc=%0d got count=%0d busy=%b want count=%0d busy=%b",
                 cyc, count_o, busy_o, s.count, s.busy);
      end
    end
    if (match_o || done_o) begin
      n_tests++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d match=%b done=%b count=%0d",
                 cyc, match_o, done_o, count_o);
      end else begin
        e = evq.pop_front();
        if (e.cyc != cyc || match_o !== 1'b1 || done_o !== e.done || count_o !== e.count) begin
          n_fail++;
          $display("FAIL pulse got cyc=%0d match=%b done=%b count=%0d want cyc=%0d match=1 done=%b count=%0d",
                   cyc, match_o, done_o, count_o, e.cyc, e.done, e.count);
        end
      end
    end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
      e = evq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_pulse cyc=%0d want match=1 done=%b count=%0d", cyc, e.done, e.count);
    end
    if (finish_req && !finished) begin
      n_tests++;
      if (snapq.size() != 0 || evq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover got snaps=%0d pulses=%0d want 0 0", snapq.size(), evq.size());
      end
      finished = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic exp_snap(input int c, input int cnt, input logic b);
    snap_t s;
    s.cyc = c; s.count = W'(cnt); s.busy = b;
    snapq.push_back(s);
  endtask

  task automatic exp_pulse(input int c, input int cnt, input logic d);
    pulse_t e;
    e.cyc = c; e.count = W'(cnt); e.done = d;
    evq.push_back(e);
  endtask

  // One-shot run with enable held high: terminal at edge lim+1 after the start edge.
  task automatic run_cont(input int lim);
    int c;
    c = cyc;
    start_i = 1'b1; limit_i = W'(lim); enable_i = 1'b1;
    exp_snap(c + 1, 0, 1'b1);
    exp_snap(c + lim + 1, lim, 1'b1);
    exp_pulse(c + lim + 2, lim, 1'b1);
    exp_snap(c + lim + 2, lim, 1'b0);
    exp_snap(c + lim + 3, lim, 1'b0);
    step();
    start_i = 1'b0;
    repeat (lim + 3) step();
  endtask

  initial begin
    int c;
    int tog_cnt[7];
    tog_cnt[0] = 0; tog_cnt[1] = 1; tog_cnt[2] = 1; tog_cnt[3] = 2;
    tog_cnt[4] = 2; tog_cnt[5] = 3; tog_cnt[6] = 3;

    repeat (2) step();
    rstn_i = 1'b1;
    exp_snap(cyc + 1, 0, 1'b0);
    step();
    step();

`ifndef MATCH_COUNT_AUTO_RELOAD_EN
    // limit 5, continuous enable, full count trace
    c = cyc;
    start_i = 1'b1; limit_i = W'(5); enable_i = 1'b1;
    for (int k = 0; k <= 5; k++) exp_snap(c + 1 + k, k, 1'b1);
    exp_pulse(c + 7, 5, 1'b1);
    exp_snap(c + 7, 5, 1'b0);
    exp_snap(c + 9, 5, 1'b0);
    step();
    start_i = 1'b0;
    repeat (9) step();

    // limit 3, enable toggling 1,0,1,0...
    c = cyc;
    start_i = 1'b1; limit_i = W'(3); enable_i = 1'b0;
    for (int k = 0; k < 7; k++) exp_snap(c + 1 + k, tog_cnt[k], 1'b1);
    exp_pulse(c + 8, 3, 1'b1);
    exp_snap(c + 8, 3, 1'b0);
    step();
    start_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      enable_i = (k % 2 == 1);
      step();
    end
    enable_i = 1'b0;

    run_cont(0);
    run_cont(8191);
`endif

    // clear together with start in IDLE: no start accepted, count zeroed
    c = cyc;
    start_i = 1'b1; clear_i = 1'b1; limit_i = W'(4); enable_i = 1'b1;
    exp_snap(c + 1, 0, 1'b0);
    exp_snap(c + 8, 0, 1'b0);
    step();
    start_i = 1'b0; clear_i = 1'b0;
    repeat (8) step();

`ifndef MATCH_COUNT_AUTO_RELOAD_EN
    // restart on the same cycle done is high
    c = cyc;
    start_i = 1'b1; limit_i = W'(1); enable_i = 1'b1;
    exp_snap(c + 1, 0, 1'b1);
    exp_pulse(c + 3, 1, 1'b1);
    exp_pulse(c + 5, 0, 1'b1);
    exp_snap(c + 4, 0, 1'b1);
    exp_snap(c + 5, 0, 1'b0);
    step();
    start_i = 1'b0;
    step();
    step();
    start_i = 1'b1; limit_i = W'(0);
    step();
    start_i = 1'b0;
    repeat (4) step();
`endif

    // clear at count 2 with limit 9
    c = cyc;
    start_i = 1'b1; limit_i = W'(9); enable_i = 1'b1;
    exp_snap(c + 3, 2, 1'b1);
    exp_snap(c + 4, 0, 1'b0);
    exp_snap(c + 16, 0, 1'b0);
    step();
    start_i = 1'b0;
    step();
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (14) step();

    // clear coincident with the terminal cycle
    c = cyc;
    start_i = 1'b1; limit_i = W'(2); enable_i = 1'b1;
    exp_snap(c + 3, 2, 1'b1);
    exp_snap(c + 4, 0, 1'b0);
    exp_snap(c + 8, 0, 1'b0);
    step();
    start_i = 1'b0;
    step();
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (5) step();

`ifndef MATCH_COUNT_AUTO_RELOAD_EN
    // start and limit changes during RUN are ignored
    c = cyc;
    start_i = 1'b1; limit_i = W'(4); enable_i = 1'b1;
    exp_snap(c + 3, 2, 1'b1);
    exp_pulse(c + 6, 4, 1'b1);
    exp_snap(c + 6, 4, 1'b0);
    exp_snap(c + 8, 4, 1'b0);
    step();
    start_i = 1'b0;
    step();
    start_i = 1'b1; limit_i = W'(1);
    step();
    step();
    start_i = 1'b0; limit_i = W'(0);
    repeat (5) step();
`endif

    // asynchronous reset mid-RUN, asserted between clock edges
    c = cyc;
    start_i = 1'b1; limit_i = W'(20); enable_i = 1'b1;
    exp_snap(c + 5, 4, 1'b1);
    step();
    start_i = 1'b0;
    repeat (4) step();
    @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    exp_snap(cyc, 0, 1'b0);
    @(negedge clk_i);
    #2;
    rstn_i = 1'b1;
    exp_snap(cyc + 20, 0, 1'b0);
    repeat (25) step();

`ifdef MATCH_COUNT_AUTO_RELOAD_EN
    // auto reload, limit 2: 0,1,2,0,1,2... match every 3rd cycle, then clear
    c = cyc;
    start_i = 1'b1; limit_i = W'(2); enable_i = 1'b1;
    exp_snap(c + 1, 0, 1'b1);
    exp_snap(c + 2, 1, 1'b1);
    exp_snap(c + 3, 2, 1'b1);
    for (int r = 0; r < 4; r++) begin
      exp_pulse(c + 4 + 3 * r, 0, 1'b0);
      exp_snap(c + 4 + 3 * r, 0, 1'b1);
    end
    exp_snap(c + 14, 1, 1'b1);
    exp_snap(c + 15, 0, 1'b0);
    step();
    start_i = 1'b0;
    repeat (13) step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (5) step();

    // auto reload, limit 0: match held high on back-to-back terminals
    c = cyc;
    start_i = 1'b1; limit_i = W'(0); enable_i = 1'b1;
    for (int r = 2; r <= 5; r++) exp_pulse(c + r, 0, 1'b0);
    exp_snap(c + 5, 0, 1'b1);
    exp_snap(c + 6, 0, 1'b0);
    step();
    start_i = 1'b0;
    repeat (4) step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (5) step();
`endif

    repeat (3) step();
    finish_req = 1'b1;
    repeat (3) step();
    if (!finished) $display("FAIL monitor_stalled got finished=0 want 1");
    $display("[TB] %0d tests run, %0d failed", n_tests, finished ? n_fail : n_fail + 1);
    $finish;
  end

endmodule
